// File: rtl/cmac_link_manager.sv
// CMAC RX bring-up sequencer: datapath reset, alignment wait, link debounce and auto RS-FEC hunting.
// Optional link_drops/fec_toggles statistics are built only when CMAC_LINK_STATS_EN is defined.
module cmac_link_manager #(
    parameter int unsigned RESET_CYC    = 50,
    parameter int unsigned SETTLE_CYC   = 1024,
    parameter int unsigned ALIGN_TO_CYC = 644531250,
    parameter int unsigned STABLE_CYC   = 4096
) (
    input  logic        rx_clk,
    input  logic        rx_reset,
    input  logic        sync_rx_aligned,
    input  logic [1:0]  fec_mode,
    output logic        rsfec_enable,
    output logic        reset_rx_datapath,
    output logic        link_up,
    output logic [2:0]  fsm_state,
    output logic [15:0] link_drops,
    output logic [15:0] fec_toggles
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_SETTLE = 3'd1,
        S_WAIT   = 3'd2,
        S_QUAL   = 3'd3,
        S_UP     = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] timer, timer_nxt;
    logic [31:0] qual_cnt, qual_nxt;
    logic        rsfec_nxt, rst_dp_nxt, link_up_nxt;
    logic        auto_fec, auto_fec_nxt;
    logic [1:0]  mode_q;
    logic        mode_valid;
    logic        mode_auto, mode_q_auto, mode_changed, fec_sel;

    // Modes 0 and 3 are both "auto", so switching between them is not a change.
    assign mode_auto    = (fec_mode == 2'd0) || (fec_mode == 2'd3);
    assign mode_q_auto  = (mode_q == 2'd0) || (mode_q == 2'd3);
    assign mode_changed = mode_valid && (fec_mode != mode_q) && !(mode_auto && mode_q_auto);
    assign fec_sel      = (fec_mode == 2'd1) ? 1'b1 :
                          (fec_mode == 2'd2) ? 1'b0 : auto_fec;
    assign fsm_state    = state;

    always_comb begin
        state_nxt    = state;
        timer_nxt    = (timer != 32'd0) ? timer - 32'd1 : timer;
        qual_nxt     = qual_cnt;
        rsfec_nxt    = rsfec_enable;
        rst_dp_nxt   = reset_rx_datapath;
        link_up_nxt  = link_up;
        auto_fec_nxt = auto_fec;
        if (mode_changed) begin
            state_nxt   = S_RESET;
            timer_nxt   = RESET_CYC - 1;
            rst_dp_nxt  = 1'b1;
            link_up_nxt = 1'b0;
            rsfec_nxt   = fec_sel;
        end else begin
            case (state)
                S_RESET: begin
                    rsfec_nxt = fec_sel;
                    if (timer == 32'd0) begin
                        state_nxt  = S_SETTLE;
                        timer_nxt  = SETTLE_CYC - 1;
                        rst_dp_nxt = 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (timer == 32'd0) begin
                        state_nxt = S_WAIT;
                        timer_nxt = ALIGN_TO_CYC - 1;
                    end
                end
                S_WAIT: begin
                    if (sync_rx_aligned) begin
                        state_nxt = S_QUAL;
                        qual_nxt  = STABLE_CYC - 1;
                    end else if (timer == 32'd0) begin
                        state_nxt  = S_RESET;
                        timer_nxt  = RESET_CYC - 1;
                        rst_dp_nxt = 1'b1;
                        if (mode_auto) begin
                            auto_fec_nxt = ~auto_fec;
                            rsfec_nxt    = ~auto_fec;
                        end
                    end
                end
                S_QUAL: begin
                    // The alignment timer keeps running, so a glitch late in QUAL can time out right away.
                    if (!sync_rx_aligned) begin
                        state_nxt = S_WAIT;
                    end else if (qual_cnt == 32'd0) begin
                        state_nxt   = S_UP;
                        link_up_nxt = 1'b1;
                    end else begin
                        qual_nxt = qual_cnt - 32'd1;
                    end
                end
                S_UP: begin
                    if (!sync_rx_aligned) begin
                        state_nxt   = S_RESET;
                        timer_nxt   = RESET_CYC - 1;
                        rst_dp_nxt  = 1'b1;
                        link_up_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt   = S_RESET;
                    timer_nxt   = RESET_CYC - 1;
                    rst_dp_nxt  = 1'b1;
                    link_up_nxt = 1'b0;
                end
            endcase
        end
    end

    // Timer holds the cycles remaining after the current one, hence the -1 loads.
    always_ff @(posedge rx_clk or posedge rx_reset) begin
        if (rx_reset) begin
            state             <= S_RESET;
            timer             <= RESET_CYC - 1;
            qual_cnt          <= 32'd0;
            rsfec_enable      <= 1'b1;
            reset_rx_datapath <= 1'b1;
            link_up           <= 1'b0;
            auto_fec          <= 1'b1;
            mode_q            <= 2'd0;
            mode_valid        <= 1'b0;
        end else begin
            state             <= state_nxt;
            timer             <= timer_nxt;
            qual_cnt          <= qual_nxt;
            rsfec_enable      <= rsfec_nxt;
            reset_rx_datapath <= rst_dp_nxt;
            link_up           <= link_up_nxt;
            auto_fec          <= auto_fec_nxt;
            mode_q            <= fec_mode;
            mode_valid        <= 1'b1;
        end
    end

`ifdef CMAC_LINK_STATS_EN
    logic drop_evt, toggle_evt;

    assign drop_evt   = !mode_changed && (state == S_UP) && !sync_rx_aligned;
    assign toggle_evt = !mode_changed && (state == S_WAIT) && !sync_rx_aligned &&
                        (timer == 32'd0) && mode_auto;

    always_ff @(posedge rx_clk or posedge rx_reset) begin
        if (rx_reset) begin
            link_drops  <= 16'd0;
            fec_toggles <= 16'd0;
        end else begin
            if (drop_evt && (link_drops != 16'hFFFF))
                link_drops <= link_drops + 16'd1;
            if (toggle_evt && (fec_toggles != 16'hFFFF))
                fec_toggles <= fec_toggles + 16'd1;
        end
    end
`else
    assign link_drops  = 16'h0;
    assign fec_toggles = 16'h0;
`endif

endmodule

// File: tb/tb_cmac_link_manager.sv
// Bench for cmac_link_manager: directed bring-up scenarios plus random alignment/mode traffic,
// every cycle compared against a phase/elapsed-time reference model.
module tb_cmac_link_manager;

    localparam int RST_N    = 4;
    localparam int SET_N    = 8;
    localparam int ALIGN_N  = 100;
    localparam int STABLE_N = 16;

    logic        rx_clk = 1'b0;
    logic        rx_reset;
    logic        sync_rx_aligned;
    logic [1:0]  fec_mode;
    logic        rsfec_enable;
    logic        reset_rx_datapath;
    logic        link_up;
    logic [2:0]  fsm_state;
    logic [15:0] link_drops;
    logic [15:0] fec_toggles;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0..4 = reset/settle/wait/qual/up, with elapsed-cycle counters.
    int         mPhase, mAge, mWaitAge, mRun, mDrops, mToggles;
    bit         mAutoFec, mFec, mModeValid;
    logic [1:0] mPrevMode;

    always #5 rx_clk = ~rx_clk;

    cmac_link_manager #(
        .RESET_CYC(RST_N), .SETTLE_CYC(SET_N), .ALIGN_TO_CYC(ALIGN_N), .STABLE_CYC(STABLE_N)
    ) dut (
        .rx_clk(rx_clk), .rx_reset(rx_reset), .sync_rx_aligned(sync_rx_aligned),
        .fec_mode(fec_mode), .rsfec_enable(rsfec_enable), .reset_rx_datapath(reset_rx_datapath),
        .link_up(link_up), .fsm_state(fsm_state), .link_drops(link_drops), .fec_toggles(fec_toggles)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int effMode(input logic [1:0] m);
        return (m == 2'd0 || m == 2'd3) ? 0 : int'(m);
    endfunction

    function automatic bit selFor(input logic [1:0] m, input bit autoVal);
        if (m == 2'd1) return 1'b1;
        if (m == 2'd2) return 1'b0;
        return autoVal;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic modelReset();
        mPhase = 0; mAge = 0; mWaitAge = 0; mRun = 0;
        mAutoFec = 1'b1; mFec = 1'b1; mDrops = 0; mToggles = 0;
        mModeValid = 1'b0; mPrevMode = 2'd0;
    endtask

    task automatic modelEnterReset(input logic [1:0] m);
        mPhase = 0;
        mAge   = 0;
        mFec   = selFor(m, mAutoFec);
    endtask

    task automatic modelStep(input bit a, input logic [1:0] m);
        if (mModeValid && effMode(m) != effMode(mPrevMode)) begin
            modelEnterReset(m);
        end else begin
            case (mPhase)
                0: begin
                    mFec = selFor(m, mAutoFec);
                    mAge++;
                    if (mAge == RST_N) begin mPhase = 1; mAge = 0; end
                end
                1: begin
                    mAge++;
                    if (mAge == SET_N) begin mPhase = 2; mWaitAge = 0; end
                end
                2: begin
                    if (a) begin
                        mPhase = 3; mRun = 0; mWaitAge++;
                    end else if (mWaitAge >= ALIGN_N - 1) begin
                        if (effMode(m) == 0) begin
                            mAutoFec = !mAutoFec;
                            mToggles = sat16(mToggles + 1);
                        end
                        modelEnterReset(m);
                    end else begin
                        mWaitAge++;
                    end
                end
                3: begin
                    mWaitAge++;
                    if (!a) mPhase = 2;
                    else begin
                        mRun++;
                        if (mRun == STABLE_N) mPhase = 4;
                    end
                end
                default: begin
                    if (!a) begin
                        mDrops = sat16(mDrops + 1);
                        modelEnterReset(m);
                    end
                end
            endcase
        end
        mPrevMode  = m;
        mModeValid = 1'b1;
    endtask

    function automatic logic [63:0] modelVec();
        logic [15:0] d, t;
`ifdef CMAC_LINK_STATS_EN
        d = mDrops[15:0];
        t = mToggles[15:0];
`else
        d = 16'h0;
        t = 16'h0;
`endif
        return {26'b0, 3'(mPhase), mFec, (mPhase == 0), (mPhase == 4), d, t};
    endfunction

    function automatic logic [63:0] dutVec();
        return {26'b0, fsm_state, rsfec_enable, reset_rx_datapath, link_up, link_drops, fec_toggles};
    endfunction

    task automatic applyStimulus(input logic a, input logic [1:0] m);
        sync_rx_aligned = a;
        fec_mode        = m;
        @(posedge rx_clk);
        modelStep(a, m);
        #1;
        checkOutput("cycle", dutVec(), modelVec());
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  pulse, flips;
        bit  prevFec, a;
        logic [1:0] m;

        rx_reset = 1'b1; sync_rx_aligned = 1'b0; fec_mode = 2'd0;
        repeat (3) @(posedge rx_clk);
        #1;
        checkOutput("rst_state", fsm_state, 0);
        checkOutput("rst_rdp", reset_rx_datapath, 1);
        checkOutput("rst_link", link_up, 0);
        checkOutput("rst_fec", rsfec_enable, 1);
        checkOutput("rst_drops", link_drops, 0);
        checkOutput("rst_toggles", fec_toggles, 0);

        // Bring-up with alignment appearing at cycle 20.
        rx_reset = 1'b0;
        modelReset();
        pulse = reset_rx_datapath ? 1 : 0;
        for (int i = 0; i < 45; i++) begin
            applyStimulus(i >= 20, 2'd0);
            if (reset_rx_datapath) pulse++;
        end
        checkOutput("bringup_pulse", pulse, RST_N);
        checkOutput("bringup_link", link_up, 1);
        checkOutput("bringup_fec", rsfec_enable, 1);

        // One-cycle loss of alignment while up.
        applyStimulus(1'b0, 2'd0);
        checkOutput("drop_link", link_up, 0);
        pulse = reset_rx_datapath ? 1 : 0;
        for (int i = 0; i < 35; i++) begin
            applyStimulus(1'b1, 2'd0);
            if (reset_rx_datapath) pulse++;
        end
        checkOutput("drop_pulse", pulse, RST_N);
        checkOutput("drop_fec", rsfec_enable, 1);
        checkOutput("drop_relink", link_up, 1);
`ifdef CMAC_LINK_STATS_EN
        checkOutput("drop_count", link_drops, 1);
`endif

        // Glitch inside qualification at qual count 5.
        applyStimulus(1'b0, 2'd0);
        for (int i = 0; i < 40 && fsm_state != 3'd3; i++) applyStimulus(1'b1, 2'd0);
        checkOutput("reach_qual", fsm_state, 3);
        repeat (10) applyStimulus(1'b1, 2'd0);
        applyStimulus(1'b0, 2'd0);
        checkOutput("glitch_state", fsm_state, 2);
        checkOutput("glitch_rdp", reset_rx_datapath, 0);
        checkOutput("glitch_link", link_up, 0);
        repeat (25) applyStimulus(1'b1, 2'd0);
        checkOutput("requal_link", link_up, 1);

        // Force FEC off while up; timeouts must not toggle it.
        applyStimulus(1'b1, 2'd2);
        checkOutput("force_state", fsm_state, 0);
        checkOutput("force_fec", rsfec_enable, 0);
        checkOutput("force_link", link_up, 0);
        repeat (240) applyStimulus(1'b0, 2'd2);
        checkOutput("force_keep_fec", rsfec_enable, 0);

        // Back to auto: three timeouts flip FEC 1->0->1->0.
        applyStimulus(1'b0, 2'd0);
        checkOutput("auto_fec_start", rsfec_enable, 1);
        flips = 0;
        prevFec = rsfec_enable;
        for (int i = 0; i < 345; i++) begin
            applyStimulus(1'b0, 2'd0);
            if (rsfec_enable != prevFec) flips++;
            prevFec = rsfec_enable;
        end
        checkOutput("auto_flips", flips, 3);
        checkOutput("auto_fec_end", rsfec_enable, 0);
`ifdef CMAC_LINK_STATS_EN
        checkOutput("auto_toggles", fec_toggles, 3);
`endif

        // Asynchronous reset while waiting for alignment.
        for (int i = 0; i < 30 && fsm_state != 3'd2; i++) applyStimulus(1'b0, 2'd0);
        checkOutput("reach_wait", fsm_state, 2);
        #2 rx_reset = 1'b1;
        #1;
        checkOutput("async_state", fsm_state, 0);
        checkOutput("async_rdp", reset_rx_datapath, 1);
        checkOutput("async_link", link_up, 0);
        checkOutput("async_fec", rsfec_enable, 1);
        checkOutput("async_drops", link_drops, 0);
        checkOutput("async_toggles", fec_toggles, 0);
        @(posedge rx_clk);
        #1 rx_reset = 1'b0;
        modelReset();

        // Random alignment bursts, glitches and occasional mode changes.
        a = 1'b0;
        m = 2'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) a = !a;
            if ($urandom_range(0, 599) == 0) m = 2'($urandom_range(0, 3));
            if (a && $urandom_range(0, 99) == 0) applyStimulus(1'b0, m);
            else applyStimulus(a, m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
